// File: rtl/dcache_store_buffer_pkg.sv
// Shared store-buffer types: store-type encoding, buffered entry payload and a
// strobe-to-byte-mask helper.
package dcache_store_buffer_pkg;

  // size in [3:2], left_or_right in [1:0] of the 4-bit st_type port
  typedef struct packed {
    logic [1:0] size;
    logic [1:0] left_or_right;
  } store_type_t;

  localparam logic [1:0] STORETYPE_SB = 2'b00;
  localparam logic [1:0] STORETYPE_SH = 2'b01;
  localparam logic [1:0] STORETYPE_SW = 2'b10;

  localparam logic [1:0] LR_NONE  = 2'b00;
  localparam logic [1:0] LR_RIGHT = 2'b01;
  localparam logic [1:0] LR_LEFT  = 2'b10;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sb_entry_t;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

endpackage

// File: rtl/dcache_store_buffer_align.sv
// Combinational store alignment: turns a store type, byte offset and rt value
// into a word write with byte strobes; unstrobed bytes come out as zero.
module dcache_store_buffer_align
  import dcache_store_buffer_pkg::*;
(
  input  logic [3:0]  st_type,
  input  logic [1:0]  byte_off,
  input  logic [31:0] st_rt,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        legal
);

  store_type_t st;
  logic [31:0] raw;

  assign st = store_type_t'(st_type);

  // Strobe and unmasked lane data for every legal store flavour
  always_comb begin
    wstrb = 4'b0000;
    raw   = 32'h0000_0000;
    legal = 1'b1;
    case (st.left_or_right)
      LR_LEFT: begin
        case (byte_off)
          2'b00:   begin wstrb = 4'b0001; raw = {24'h00_0000, st_rt[31:24]}; end
          2'b01:   begin wstrb = 4'b0011; raw = {16'h0000, st_rt[31:16]}; end
          2'b10:   begin wstrb = 4'b0111; raw = {8'h00, st_rt[31:8]}; end
          default: begin wstrb = 4'b1111; raw = st_rt; end
        endcase
      end
      LR_RIGHT: begin
        case (byte_off)
          2'b00:   begin wstrb = 4'b1111; raw = st_rt; end
          2'b01:   begin wstrb = 4'b1110; raw = {st_rt[23:0], 8'h00}; end
          2'b10:   begin wstrb = 4'b1100; raw = {st_rt[15:0], 16'h0000}; end
          default: begin wstrb = 4'b1000; raw = {st_rt[7:0], 24'h00_0000}; end
        endcase
      end
      LR_NONE: begin
        case (st.size)
          STORETYPE_SB: begin
            wstrb = 4'b0001 << byte_off;
            raw   = {4{st_rt[7:0]}};
          end
          STORETYPE_SH: begin
            // odd halfword offsets are trapped upstream, so only byte_off[1] matters
            if (byte_off[1]) begin
              wstrb = 4'b1100;
            end else begin
              wstrb = 4'b0011;
            end
            raw = {2{st_rt[15:0]}};
          end
          STORETYPE_SW: begin
            wstrb = 4'b1111;
            raw   = st_rt;
          end
          default: begin
            legal = 1'b0;
          end
        endcase
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  assign wdata = raw & strb_to_mask(wstrb);

endmodule

// File: rtl/dcache_store_buffer_chk.sv
// Simulation checks for the store buffer: illegal store types and occupancy bound.
module dcache_store_buffer_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          st_valid,
  input logic          legal,
  input logic [CW-1:0] count
);

  illegal_store_type: assert property (@(posedge clk) disable iff (rst) st_valid |-> legal);

  count_in_range: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));

endmodule

// File: rtl/dcache_store_buffer.sv
// Store buffer between MEM2 and the D-cache write port: aligns committed stores
// and drains them in order. Define DCACHE_SB_FWD_EN for store-to-load forwarding.
module dcache_store_buffer
  import dcache_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic [3:0]             st_type,
  input  logic [AW-1:0]          st_addr,
  input  logic [31:0]            st_rt,
  output logic                   st_ready,
  output logic                   wr_valid,
  output logic [AW-1:0]          wr_addr,
  output logic [3:0]             wr_wstrb,
  output logic [31:0]            wr_wdata,
  input  logic                   wr_ready,
  output logic                   sb_empty,
  output logic [$clog2(DEPTH):0] sb_count
`ifdef DCACHE_SB_FWD_EN
  ,
  input  logic [AW-1:0]          ld_addr,
  output logic [3:0]             fwd_mask,
  output logic [31:0]            fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [AW-1:0] addr_mem [DEPTH];
  sb_entry_t     ent_mem  [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          legal;
  logic [3:0]    al_wstrb;
  logic [31:0]   al_wdata;
  logic          push;
  logic          pop;

  dcache_store_buffer_align u_align (
    .st_type  (st_type),
    .byte_off (st_addr[1:0]),
    .st_rt    (st_rt),
    .wstrb    (al_wstrb),
    .wdata    (al_wdata),
    .legal    (legal)
  );

  dcache_store_buffer_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .legal    (legal),
    .count    (count)
  );

  // st_ready depends only on count, so a full buffer never accepts even while draining
  assign st_ready = (count != CNT_FULL);
  assign wr_valid = (count != '0);
  assign sb_empty = (count == '0);
  assign sb_count = count;
  assign push     = st_valid && st_ready && legal;
  assign pop      = wr_valid && wr_ready;

  // FIFO storage, pointers and occupancy; storage is cleared so wr_* reads zero after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        ent_mem[i]  <= '0;
      end
    end else begin
      if (push) begin
        addr_mem[tail] <= {st_addr[AW-1:2], 2'b00};
        ent_mem[tail]  <= '{wstrb: al_wstrb, wdata: al_wdata};
        tail           <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  assign wr_addr  = addr_mem[head];
  assign wr_wstrb = ent_mem[head].wstrb;
  assign wr_wdata = ent_mem[head].wdata;

`ifdef DCACHE_SB_FWD_EN
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the youngest matching entry owns each lane
  always_comb begin
    fwd_mask = 4'b0000;
    fwd_data = 32'h0000_0000;
    idx      = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (addr_mem[idx][AW-1:2] == ld_addr[AW-1:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (ent_mem[idx].wstrb[b]) begin
            fwd_mask[b]          = 1'b1;
            fwd_data[8*b +: 8]   = ent_mem[idx].wdata[8*b +: 8];
          end else begin
            fwd_mask[b]          = fwd_mask[b];
          end
        end
      end else begin
        fwd_mask = fwd_mask;
      end
    end
  end
`endif

endmodule
